i2c_arbiter: RTL and testbench

Round-robin arbiter that shares the single I2C master transaction port between N_REQ requesters: the per-camera register-map sequencers plus the host register-access path. Each requester presents one complete transaction, that is command, device address, 16-bit register address and 16-bit write data. The arbiter grants one requester at a time, forwards its fields to the master, and waits for completion or timeout. It then returns the result and a done/error strobe to the granted requester only.

---
 rtl/i2c_arb_pkg.sv | 28 ++
 rtl/i2c_rr_pick.sv | 34 +++
 rtl/i2c_arbiter.sv | 169 ++++++++++++++++
 tb/tb_i2c_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C master-port arbiter.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package i2c_arb_pkg;

    localparam int ADDR_DEV_W = 7;
    localparam int BYTE_W     = 8;

    localparam logic CMD_WR = 1'b0;
    localparam logic CMD_RD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    // One complete transaction as presented to the I2C master.
    typedef struct packed {
        logic                  cmd;
        logic [ADDR_DEV_W-1:0] addr_dev;
        logic [BYTE_W-1:0]     addr_reg_h;
        logic [BYTE_W-1:0]     addr_reg_l;
        logic [BYTE_W-1:0]     data_wr_h;
        logic [BYTE_W-1:0]     data_wr_l;
    } xact_t;

endpackage

// File: rtl/i2c_rr_pick.sv
// Round-robin pick: first set request at or after rr_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; vld low when no request is pending.
module i2c_rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    always_comb begin
        int   k;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (int'(rr_ptr) + i) % N_REQ;
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = IDX_W'(k);
            end
        end
    end

    assign vld = |req;

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master transaction port among N_REQ requesters.
// Latency: grant and fields 1 cycle after request; req_done 1 cycle after i2c_done rise.
// Backpressure: requesters hold req_rqt until req_done; one transaction in flight at a time.
module i2c_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_rqt,
    input  logic [N_REQ-1:0]            req_cmd,
    input  logic [ADDR_DEV_W*N_REQ-1:0] req_addr_dev,
    input  logic [BYTE_W*N_REQ-1:0]     req_addr_reg_H,
    input  logic [BYTE_W*N_REQ-1:0]     req_addr_reg_L,
    input  logic [BYTE_W*N_REQ-1:0]     req_data_wr_H,
    input  logic [BYTE_W*N_REQ-1:0]     req_data_wr_L,
    output logic [N_REQ-1:0]            req_gnt,
    output logic [N_REQ-1:0]            req_done,
    output logic [N_REQ-1:0]            req_err,
    output logic [BYTE_W-1:0]           data_rd,
    output logic                        busy,
    output logic                        i2c_rqt,
    output logic                        cmd,
    output logic [ADDR_DEV_W-1:0]       addr_dev,
    output logic [BYTE_W-1:0]           addr_reg_H,
    output logic [BYTE_W-1:0]           addr_reg_L,
    output logic [BYTE_W-1:0]           data_wr_H,
    output logic [BYTE_W-1:0]           data_wr_L,
    input  logic                        i2c_done,
    input  logic [BYTE_W-1:0]           i2c_data_rd
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d, done_q, done_d, err_q, err_d;
    logic [BYTE_W-1:0] data_rd_q, data_rd_d;
    logic              busy_q, busy_d, i2c_rqt_q, i2c_rqt_d;
    logic              i2c_done_q;
    xact_t             xact_q, xact_d, pick_xact;

    logic [N_REQ-1:0]  pick_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_vld;
    logic              done_edge, timeout_hit;

    i2c_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req_rqt),
        .rr_ptr (rr_ptr_q),
        .gnt    (pick_gnt),
        .idx    (pick_idx),
        .vld    (pick_vld)
    );

    always_comb begin
        pick_xact.cmd        = req_cmd[pick_idx];
        pick_xact.addr_dev   = req_addr_dev[int'(pick_idx)*ADDR_DEV_W +: ADDR_DEV_W];
        pick_xact.addr_reg_h = req_addr_reg_H[int'(pick_idx)*BYTE_W +: BYTE_W];
        pick_xact.addr_reg_l = req_addr_reg_L[int'(pick_idx)*BYTE_W +: BYTE_W];
        pick_xact.data_wr_h  = req_data_wr_H[int'(pick_idx)*BYTE_W +: BYTE_W];
        pick_xact.data_wr_l  = req_data_wr_L[int'(pick_idx)*BYTE_W +: BYTE_W];
    end

    assign done_edge   = i2c_done & ~i2c_done_q;
    // A zero timeout never fires, so the master may take arbitrarily long.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        err_d     = '0;
        data_rd_d = data_rd_q;
        busy_d    = busy_q;
        i2c_rqt_d = i2c_rqt_q;
        xact_d    = xact_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    xact_d    = pick_xact;
                    owner_d   = pick_idx;
                    gnt_d     = pick_gnt;
                    busy_d    = 1'b1;
                    i2c_rqt_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // Done takes priority over a timeout landing in the same cycle.
                if (done_edge) begin
                    data_rd_d = i2c_data_rd;
                    done_d    = gnt_q;
                    i2c_rqt_d = 1'b0;
                    state_d   = ST_RELEASE;
                end else if (timeout_hit) begin
                    done_d    = gnt_q;
                    err_d     = gnt_q;
                    i2c_rqt_d = 1'b0;
                    state_d   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                gnt_d    = '0;
                busy_d   = 1'b0;
                rr_ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            data_rd_q  <= '0;
            busy_q     <= 1'b0;
            i2c_rqt_q  <= 1'b0;
            i2c_done_q <= 1'b0;
            xact_q     <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            data_rd_q  <= data_rd_d;
            busy_q     <= busy_d;
            i2c_rqt_q  <= i2c_rqt_d;
            i2c_done_q <= i2c_done;
            xact_q     <= xact_d;
        end
    end

    assign req_gnt    = gnt_q;
    assign req_done   = done_q;
    assign req_err    = err_q;
    assign data_rd    = data_rd_q;
    assign busy       = busy_q;
    assign i2c_rqt    = i2c_rqt_q;
    assign cmd        = xact_q.cmd;
    assign addr_dev   = xact_q.addr_dev;
    assign addr_reg_H = xact_q.addr_reg_h;
    assign addr_reg_L = xact_q.addr_reg_l;
    assign data_wr_H  = xact_q.data_wr_h;
    assign data_wr_L  = xact_q.data_wr_l;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: directed scenarios plus randomized fields/latencies
// checked against a transaction-level round-robin model.
module tb_i2c_arbiter;
    import i2c_arb_pkg::*;

    localparam int N  = 2;
    localparam int TO = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N-1:0]          req_rqt = '0;
    logic [N-1:0]          req_cmd = '0;
    logic [ADDR_DEV_W*N-1:0] req_addr_dev = '0;
    logic [BYTE_W*N-1:0]   req_addr_reg_H = '0, req_addr_reg_L = '0;
    logic [BYTE_W*N-1:0]   req_data_wr_H = '0, req_data_wr_L = '0;
    logic                  i2c_done = 1'b0;
    logic [7:0]            i2c_data_rd = '0;
    logic [N-1:0]          req_gnt, req_done, req_err;
    logic [7:0]            data_rd;
    logic                  busy, i2c_rqt, cmd;
    logic [6:0]            addr_dev;
    logic [7:0]            addr_reg_H, addr_reg_L, data_wr_H, data_wr_L;
    logic [39:0]           dut_fields;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int         m_ptr = 0;
    logic [7:0] m_data_rd = '0;
    logic       m_cmd [N];
    logic [6:0] m_dev [N];
    logic [7:0] m_rh [N], m_rl [N], m_wh [N], m_wl [N];

    i2c_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_rqt(req_rqt), .req_cmd(req_cmd), .req_addr_dev(req_addr_dev),
        .req_addr_reg_H(req_addr_reg_H), .req_addr_reg_L(req_addr_reg_L),
        .req_data_wr_H(req_data_wr_H), .req_data_wr_L(req_data_wr_L),
        .req_gnt(req_gnt), .req_done(req_done), .req_err(req_err),
        .data_rd(data_rd), .busy(busy), .i2c_rqt(i2c_rqt), .cmd(cmd),
        .addr_dev(addr_dev), .addr_reg_H(addr_reg_H), .addr_reg_L(addr_reg_L),
        .data_wr_H(data_wr_H), .data_wr_L(data_wr_L),
        .i2c_done(i2c_done), .i2c_data_rd(i2c_data_rd)
    );

    always #3 clk = ~clk;

    assign dut_fields = {cmd, addr_dev, addr_reg_H, addr_reg_L, data_wr_H, data_wr_L};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input int k, input logic c, input logic [6:0] d,
                              input logic [7:0] rh, input logic [7:0] rl,
                              input logic [7:0] wh, input logic [7:0] wl);
        m_cmd[k] = c; m_dev[k] = d; m_rh[k] = rh; m_rl[k] = rl; m_wh[k] = wh; m_wl[k] = wl;
        req_cmd[k]              = c;
        req_addr_dev[k*7 +: 7]  = d;
        req_addr_reg_H[k*8 +: 8] = rh;
        req_addr_reg_L[k*8 +: 8] = rl;
        req_data_wr_H[k*8 +: 8]  = wh;
        req_data_wr_L[k*8 +: 8]  = wl;
    endtask

    task automatic rand_fields(input int k);
        set_fields(k, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom),
                   8'($urandom), 8'($urandom));
    endtask

    function automatic logic [39:0] fields_of(input int k);
        return {m_cmd[k], m_dev[k], m_rh[k], m_rl[k], m_wh[k], m_wl[k]};
    endfunction

    function automatic int model_pick(input logic [N-1:0] req, input int ptr);
        for (int i = 0; i < N; i++)
            if (req[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v = '0;
        if (k >= 0) v[k] = 1'b1;
        return v;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0; req_rqt = '0; i2c_done = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        m_ptr = 0; m_data_rd = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_rqt = '0; i2c_done = 1'b0;
        #2;
        checks++; if (i2c_rqt !== 1'b0) begin errors++; $display("FAIL reset_i2c_rqt: got %b want 0", i2c_rqt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (req_gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 00", req_gnt); end
        checks++; if (req_done !== '0 || req_err !== '0) begin errors++; $display("FAIL reset_done_err: got %b/%b want 00/00", req_done, req_err); end
        checks++; if (data_rd !== 8'h00) begin errors++; $display("FAIL reset_data_rd: got %h want 00", data_rd); end
        checks++; if (dut_fields !== 40'h0) begin errors++; $display("FAIL reset_fields: got %h want 0", dut_fields); end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++; if (req_gnt !== '0 || i2c_rqt !== 1'b0) begin errors++; $display("FAIL idle_no_req: gnt %b rqt %b want 00/0", req_gnt, i2c_rqt); end
    endtask

    task automatic test_single_write();
        int n_done;
        set_fields(0, CMD_WR, 7'h36, 8'h30, 8'h1A, 8'h00, 8'h5C);
        req_rqt = 2'b01;
        tick();
        checks++; if (i2c_rqt !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL wr_issue: rqt %b busy %b want 1/1", i2c_rqt, busy); end
        checks++; if (req_gnt !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b want 01", req_gnt); end
        checks++; if (dut_fields !== fields_of(0)) begin errors++; $display("FAIL wr_fields: got %h want %h", dut_fields, fields_of(0)); end
        i2c_data_rd = 8'h77; i2c_done = 1'b1;
        tick();
        checks++; if (req_done !== 2'b01 || req_err !== 2'b00) begin errors++; $display("FAIL wr_done: done %b err %b want 01/00", req_done, req_err); end
        checks++; if (i2c_rqt !== 1'b0 || req_gnt !== 2'b01) begin errors++; $display("FAIL wr_release: rqt %b gnt %b want 0/01", i2c_rqt, req_gnt); end
        m_data_rd = 8'h77; m_ptr = 1;
        req_rqt = '0; i2c_done = 1'b0;
        tick();
        checks++; if (req_done !== '0 || req_gnt !== '0 || busy !== 1'b0) begin errors++; $display("FAIL wr_idle: done %b gnt %b busy %b want 00/00/0", req_done, req_gnt, busy); end
        n_done = 0;
        repeat (4) begin tick(); if (req_done !== '0) n_done++; end
        checks++; if (n_done != 0) begin errors++; $display("FAIL wr_single_pulse: extra dones %0d want 0", n_done); end
    endtask

    task automatic test_read();
        int lat, early;
        set_fields(1, CMD_RD, 7'($urandom), 8'h30, 8'h0A, 8'($urandom), 8'($urandom));
        req_rqt = 2'b10;
        tick();
        checks++; if (req_gnt !== onehot(model_pick(2'b10, m_ptr))) begin errors++; $display("FAIL rd_gnt: got %b want 10", req_gnt); end
        checks++; if (dut_fields !== fields_of(1) || cmd !== CMD_RD) begin errors++; $display("FAIL rd_fields: got %h want %h", dut_fields, fields_of(1)); end
        lat = $urandom_range(1, 5);
        early = 0;
        repeat (lat) begin tick(); if (req_done !== '0) early++; end
        checks++; if (early != 0) begin errors++; $display("FAIL rd_early_done: got %0d strobes want 0", early); end
        i2c_data_rd = 8'hA5; i2c_done = 1'b1;
        tick();
        checks++; if (req_done !== 2'b10) begin errors++; $display("FAIL rd_done: got %b want 10", req_done); end
        checks++; if (data_rd !== 8'hA5) begin errors++; $display("FAIL rd_data: got %h want a5", data_rd); end
        m_data_rd = 8'hA5; m_ptr = 0;
        req_rqt = '0; i2c_done = 1'b0;
        tick();
    endtask

    task automatic test_fairness();
        int exp_k, last, served, lat;
        logic [7:0] rd;
        apply_reset();
        rand_fields(0); rand_fields(1);
        last = -1;
        for (int r = 0; r < 8; r++) begin
            req_rqt = 2'b11;
            exp_k = model_pick(req_rqt, m_ptr);
            tick();
            served = -1;
            for (int i = 0; i < N; i++) if (req_gnt[i]) served = i;
            checks++; if (req_gnt !== onehot(exp_k)) begin errors++; $display("FAIL fair_gnt r%0d: got %b want %b", r, req_gnt, onehot(exp_k)); end
            checks++; if (served == last) begin errors++; $display("FAIL fair_repeat r%0d: served %0d twice in a row", r, served); end
            checks++; if (dut_fields !== fields_of(exp_k)) begin errors++; $display("FAIL fair_fields r%0d: got %h want %h", r, dut_fields, fields_of(exp_k)); end
            lat = $urandom_range(0, 4);
            repeat (lat) tick();
            rd = 8'($urandom);
            i2c_data_rd = rd; i2c_done = 1'b1;
            tick();
            checks++; if (req_done !== onehot(exp_k) || data_rd !== rd) begin errors++; $display("FAIL fair_done r%0d: done %b data %h want %b/%h", r, req_done, data_rd, onehot(exp_k), rd); end
            m_data_rd = rd; m_ptr = (exp_k + 1) % N; last = served;
            req_rqt[exp_k] = 1'b0; i2c_done = 1'b0;
            rand_fields(exp_k);
            tick();
        end
        req_rqt = '0;
        tick();
    endtask

    task automatic test_timeout();
        int exp_k, n;
        bit got;
        logic [7:0] rd;
        rand_fields(0);
        req_rqt = 2'b01;
        exp_k = model_pick(req_rqt, m_ptr);
        tick();
        checks++; if (i2c_rqt !== 1'b1) begin errors++; $display("FAIL to_issue: rqt %b want 1", i2c_rqt); end
        n = 0; got = 0;
        while (n < 40 && !got) begin
            tick(); n++;
            if (req_done !== '0) got = 1;
        end
        checks++; if (!got || n != TO + 1) begin errors++; $display("FAIL to_latency: got done=%0d after %0d cycles want after %0d", got, n, TO + 1); end
        checks++; if (req_done !== onehot(exp_k) || req_err !== onehot(exp_k)) begin errors++; $display("FAIL to_strobes: done %b err %b want %b/%b", req_done, req_err, onehot(exp_k), onehot(exp_k)); end
        checks++; if (i2c_rqt !== 1'b0 || data_rd !== m_data_rd) begin errors++; $display("FAIL to_state: rqt %b data %h want 0/%h", i2c_rqt, data_rd, m_data_rd); end
        m_ptr = (exp_k + 1) % N;
        req_rqt = '0;
        tick();
        checks++; if (req_err !== '0 || req_gnt !== '0) begin errors++; $display("FAIL to_clear: err %b gnt %b want 00/00", req_err, req_gnt); end

        // Done edge arriving in the very cycle the counter expires.
        req_rqt = 2'b01;
        exp_k = model_pick(req_rqt, m_ptr);
        tick();
        repeat (TO) tick();
        checks++; if (req_done !== '0) begin errors++; $display("FAIL to_edge_early: done %b want 00", req_done); end
        rd = 8'($urandom);
        i2c_data_rd = rd; i2c_done = 1'b1;
        tick();
        checks++; if (req_done !== onehot(exp_k) || req_err !== '0 || data_rd !== rd) begin errors++; $display("FAIL to_edge_tie: done %b err %b data %h want %b/00/%h", req_done, req_err, data_rd, onehot(exp_k), rd); end
        m_data_rd = rd; m_ptr = (exp_k + 1) % N;
        req_rqt = '0; i2c_done = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_toggle_done();
        logic [N-1:0] exp_vec;
        logic p, c;
        bit   m_busy;
        int   m_owner, next_grant, exp_dones, got_dones, bad;
        apply_reset();
        rand_fields(0); rand_fields(1);
        req_rqt = 2'b11;
        p = 1'b0; m_busy = 0; m_owner = 0; next_grant = 0;
        exp_dones = 0; got_dones = 0; bad = 0;
        fork
            begin
                repeat (26) #10 i2c_done = ~i2c_done;
            end
        join_none
        for (int n = 0; n < 48; n++) begin
            @(posedge clk);
            c = i2c_done;
            exp_vec = '0;
            if (!m_busy) begin
                if (n >= next_grant) begin
                    m_busy = 1;
                    m_owner = model_pick(req_rqt, m_ptr);
                end
            end else if (c && !p) begin
                exp_vec = onehot(m_owner);
                m_busy = 0;
                next_grant = n + 2;
                m_ptr = (m_owner + 1) % N;
                exp_dones++;
            end
            p = c;
            #1;
            checks++;
            if (req_done !== exp_vec || req_err !== '0) begin
                errors++; bad++;
                if (bad <= 5) $display("FAIL toggle_cycle%0d: done %b err %b want %b/00", n, req_done, req_err, exp_vec);
            end
            if (req_done !== '0) got_dones++;
        end
        checks++; if (got_dones != exp_dones) begin errors++; $display("FAIL toggle_count: got %0d dones want %0d", got_dones, exp_dones); end
        apply_reset();
    endtask

    task automatic test_reset_mid_busy();
        apply_reset();
        rand_fields(0); rand_fields(1);
        req_rqt = 2'b10;
        repeat (3) tick();
        checks++; if (busy !== 1'b1 || i2c_rqt !== 1'b1) begin errors++; $display("FAIL rmb_pre: busy %b rqt %b want 1/1", busy, i2c_rqt); end
        rst_n = 1'b0;
        #1;
        checks++; if (i2c_rqt !== 1'b0 || req_gnt !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rmb_async: rqt %b gnt %b busy %b want 0/00/0", i2c_rqt, req_gnt, busy); end
        i2c_done = 1'b1;
        tick();
        checks++; if (req_done !== '0) begin errors++; $display("FAIL rmb_no_done: got %b want 00", req_done); end
        i2c_done = 1'b0;
        tick();
        req_rqt = 2'b11;
        rst_n = 1'b1;
        tick();
        checks++; if (req_gnt !== onehot(model_pick(2'b11, 0))) begin errors++; $display("FAIL rmb_first_gnt: got %b want 01", req_gnt); end
        checks++; if (dut_fields !== fields_of(0)) begin errors++; $display("FAIL rmb_fields: got %h want %h", dut_fields, fields_of(0)); end
        req_rqt = '0;
        i2c_done = 1'b1;
        tick();
        i2c_done = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read();
        test_fairness();
        test_timeout();
        test_toggle_done();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
